hiscore_upload: RTL and testbench
=================================

Name: hiscore_upload

Overview:
- Upload-side responder for the hps_io ioctl channel. Existing ROM/DIP logic only consumes downloads; this block is the return path.
- On a save request it pauses the game CPUs and snapshots LEN bytes of game work RAM into a local buffer. It then raises ioctl_upload_req and serves the buffer bytes to the HPS on ioctl_din while the upload runs.
- Sits in emu beside hps_io and the pause block. Runs on clk_53p6, which is wired to clk_sys.

Parameters:
- ADDR_W, 10, buffer/work-RAM address width; buffer depth is 2^ADDR_W.
- LEN, 64, bytes snapshotted and served; 1..2^ADDR_W.
- UPLOAD_INDEX, 8'd4, ioctl_index value this block responds to.
- TIMEOUT, 2^24, clk_sys cycles to wait in REQ for the HPS before giving up.

Ports:
- clk_sys, in, 1: system clock (53.6 MHz).
- reset, in, 1: synchronous, active-high.
- save_req, in, 1: level from OSD; a rising edge starts a snapshot.
- pause_req, out, 1: asks the pause logic to halt the CPUs.
- pause_ack, in, 1: CPUs halted.
- ram_addr, out, ADDR_W: work-RAM read address.
- ram_rd, out, 1: read strobe.
- ram_dout, in, 8: read data, valid exactly 1 cycle after ram_rd.
- ioctl_upload, in, 1: HPS upload in progress.
- ioctl_index, in, 8: upload target index.
- ioctl_rd, in, 1: HPS byte read strobe.
- ioctl_addr, in, 25: byte address of the current upload read.
- ioctl_din, out, 8: byte returned to the HPS.
- ioctl_wait, out, 1: stalls the HPS while the byte is fetched.
- ioctl_upload_req, out, 1: 1-cycle pulse asking the HPS to start an upload.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: 1-cycle pulse when an upload completes.
- error, out, 1: sticky flag for a REQ timeout; cleared by the next accepted save_req or by reset.

Behaviour:
- Reset values: every output is 0; state = IDLE; buffer valid flag = 0. Buffer contents are not cleared.
- save_req is edge-detected through a registered previous value. Edges seen outside IDLE are dropped.
- IDLE:
  - On a save_req rising edge: pause_req <= 1, error <= 0, go to PAUSE_WAIT.
  - If ioctl_upload=1 and ioctl_index=UPLOAD_INDEX (HPS-initiated upload), go directly to SERVE.
- PAUSE_WAIT: hold pause_req=1 until pause_ack=1, then go to COPY with the read counter at 0. There is no timeout in this state.
- COPY:
  - Issue ram_rd with ram_addr = 0..LEN-1 on consecutive cycles.
  - Each ram_dout is written to buffer[addr] one cycle after its read.
  - The state ends on the cycle the byte at address LEN-1 is written, so COPY lasts LEN+1 cycles. On that cycle:
    - set the valid flag;
    - drop pause_req;
    - pulse ioctl_upload_req for 1 cycle;
    - go to REQ.
- REQ:
  - Wait for ioctl_upload=1 with ioctl_index=UPLOAD_INDEX, then go to SERVE.
  - A counter reaching TIMEOUT-1 sets error=1 and returns to IDLE.
- SERVE:
  - On ioctl_rd: ioctl_wait <= 1 on the next edge, and the buffer read launches.
  - One cycle later, ioctl_din <= buffer byte and ioctl_wait <= 0. ioctl_wait is therefore high for exactly 1 cycle per read.
  - ioctl_din returns 8'hFF when ioctl_addr >= LEN, when ioctl_addr[24:ADDR_W] != 0, or when the valid flag is 0.
  - An ioctl_rd arriving while ioctl_wait=1 is ignored.
  - On the falling edge of ioctl_upload: pulse done for 1 cycle and go to IDLE.
- Buffer: single-clock RAM, 1 write port (COPY) and 1 read port (SERVE), read latency 1. Must infer as block RAM.
- Reset mid-operation: return to IDLE the following cycle. pause_req, ioctl_wait and busy drop to 0 immediately. The valid flag is cleared. A partially copied buffer is never served as valid.
- Non-matching ioctl_index uploads never affect state or outputs. ioctl_din is held at its last value and ioctl_wait stays 0.

Test Plan:
- LEN=64, RAM[i]=i^8'h5A. Pulse save_req; assert pause_ack 10 cycles after pause_req. Check:
  - ram_rd runs for 64 consecutive cycles at addresses 0..63;
  - pause_req drops and ioctl_upload_req pulses once, on the same cycle;
  - HPS upload at index 4 reading addresses 0..63 returns bytes i^5A;
  - ioctl_wait is high for exactly 1 cycle per read;
  - done pulses after ioctl_upload falls.
- During SERVE, read ioctl_addr=64 and ioctl_addr=25'h100000 -> ioctl_din=8'hFF for both.
- Upload at index 4 straight after reset with no save -> every byte is 8'hFF, busy=1 only while ioctl_upload=1.
- TIMEOUT=100, no HPS response after ioctl_upload_req -> error=1 at cycle 100, state returns to IDLE. The next save_req clears error.
- Assert reset midway through COPY (address 30) -> pause_req=0 on the next cycle. A following upload returns 8'hFF (valid flag cleared).
- Toggle save_req while in REQ; run an upload at index 3 -> no new snapshot, no ioctl_din change, ioctl_wait stays 0.

Source files
------------

// File: rtl/hiscore_upload.sv
// Return path for the hps_io ioctl channel: pauses the game, snapshots LEN bytes
// of work RAM into a local buffer, then serves that buffer to the HPS upload.
module hiscore_upload #(
  parameter int         ADDR_W       = 10,
  parameter int         LEN          = 64,
  parameter logic [7:0] UPLOAD_INDEX = 8'd4,
  parameter int         TIMEOUT      = 1 << 24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              save_req,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_dout,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam int                TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W + 1)'(LEN);
  localparam logic [24:0]       LEN_25   = 25'(LEN);

  typedef enum logic [2:0] {ST_IDLE, ST_PAUSE_WAIT, ST_COPY, ST_REQ, ST_SERVE} state_t;

  state_t            state_reg, state_next;
  logic              save_prev_reg, upload_prev_reg;
  logic              pause_req_reg, pause_req_next;
  logic              error_reg, error_next;
  logic              valid_reg, valid_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic              upload_req_reg, upload_req_next;
  logic              done_reg, done_next;
  logic              ioctl_wait_reg, ioctl_wait_next;
  logic [7:0]        ioctl_din_reg, ioctl_din_next;
  logic              oob_reg, oob_next;
  logic              buf_rd_en, buf_we;
  logic [ADDR_W-1:0] buf_wa;
  logic [7:0]        buf_q_reg;
  logic [7:0]        buf_mem [DEPTH];

  logic save_edge, hps_match, upload_fall, addr_oob;

  assign save_edge   = save_req & ~save_prev_reg;
  assign hps_match   = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
  assign upload_fall = upload_prev_reg & ~ioctl_upload;
  assign addr_oob    = (ioctl_addr >= LEN_25) || (ioctl_addr[24:ADDR_W] != '0) || !valid_reg;

  // Read address k goes out in COPY cycle k; its data lands in the buffer in cycle k+1.
  assign ram_rd   = (state_reg == ST_COPY) && (cnt_reg < CNT_LAST);
  assign ram_addr = ram_rd ? cnt_reg[ADDR_W-1:0] : '0;
  assign buf_we   = (state_reg == ST_COPY) && (cnt_reg != '0);
  assign buf_wa   = ADDR_W'(cnt_reg - 1'b1);

  always_comb begin
    state_next      = state_reg;
    pause_req_next  = pause_req_reg;
    error_next      = error_reg;
    valid_next      = valid_reg;
    cnt_next        = cnt_reg;
    to_cnt_next     = to_cnt_reg;
    upload_req_next = 1'b0;
    done_next       = 1'b0;
    ioctl_wait_next = 1'b0;
    ioctl_din_next  = ioctl_din_reg;
    oob_next        = oob_reg;
    buf_rd_en       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (save_edge) begin
          pause_req_next = 1'b1;
          error_next     = 1'b0;
          state_next     = ST_PAUSE_WAIT;
        end else if (hps_match) begin
          state_next = ST_SERVE;
        end
      end
      ST_PAUSE_WAIT: begin
        if (pause_ack) begin
          cnt_next   = '0;
          state_next = ST_COPY;
        end
      end
      ST_COPY: begin
        if (cnt_reg == CNT_LAST) begin
          valid_next      = 1'b1;
          pause_req_next  = 1'b0;
          upload_req_next = 1'b1;
          to_cnt_next     = '0;
          state_next      = ST_REQ;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_REQ: begin
        if (hps_match) begin
          state_next = ST_SERVE;
        end else if (to_cnt_reg == TO_LAST) begin
          error_next = 1'b1;
          state_next = ST_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      ST_SERVE: begin
        if (upload_fall) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (ioctl_rd && hps_match && !ioctl_wait_reg) begin
          ioctl_wait_next = 1'b1;
          buf_rd_en       = 1'b1;
          oob_next        = addr_oob;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Second half of a read: buffer data (or the filler byte) is ready now.
    if (ioctl_wait_reg) begin
      ioctl_din_next = oob_reg ? 8'hFF : buf_q_reg;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      save_prev_reg   <= 1'b0;
      upload_prev_reg <= 1'b0;
      pause_req_reg   <= 1'b0;
      error_reg       <= 1'b0;
      valid_reg       <= 1'b0;
      cnt_reg         <= '0;
      to_cnt_reg      <= '0;
      upload_req_reg  <= 1'b0;
      done_reg        <= 1'b0;
      ioctl_wait_reg  <= 1'b0;
      ioctl_din_reg   <= 8'h00;
      oob_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      save_prev_reg   <= save_req;
      upload_prev_reg <= ioctl_upload;
      pause_req_reg   <= pause_req_next;
      error_reg       <= error_next;
      valid_reg       <= valid_next;
      cnt_reg         <= cnt_next;
      to_cnt_reg      <= to_cnt_next;
      upload_req_reg  <= upload_req_next;
      done_reg        <= done_next;
      ioctl_wait_reg  <= ioctl_wait_next;
      ioctl_din_reg   <= ioctl_din_next;
      oob_reg         <= oob_next;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (buf_we) buf_mem[buf_wa] <= ram_dout;
  end

  always_ff @(posedge clk_sys) begin
    if (buf_rd_en) buf_q_reg <= buf_mem[ioctl_addr[ADDR_W-1:0]];
  end

  assign pause_req        = pause_req_reg;
  assign ioctl_din        = ioctl_din_reg;
  assign ioctl_wait       = ioctl_wait_reg;
  assign ioctl_upload_req = upload_req_reg;
  assign busy             = (state_reg != ST_IDLE);
  assign done             = done_reg;
  assign error            = error_reg;

endmodule

// File: tb/tb_hiscore_upload.sv
// Randomized scoreboard bench for hiscore_upload: snapshot, serve, timeout,
// foreign-index uploads and reset in the middle of a copy.
module tb_hiscore_upload;
  localparam int         ADDR_W  = 10;
  localparam int         LEN     = 64;
  localparam int         TIMEOUT = 100;
  localparam logic [7:0] IDX     = 8'd4;

  logic              clk_sys = 1'b0;
  logic              reset, save_req, pause_ack;
  logic              pause_req, ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ioctl_upload, ioctl_rd;
  logic [7:0]        ioctl_index, ioctl_din;
  logic [24:0]       ioctl_addr;
  logic              ioctl_wait, ioctl_upload_req, busy, done, error;

  always #5 clk_sys = ~clk_sys;

  hiscore_upload #(.ADDR_W(ADDR_W), .LEN(LEN), .UPLOAD_INDEX(IDX), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset(reset), .save_req(save_req),
    .pause_req(pause_req), .pause_ack(pause_ack),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_dout(ram_dout),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .busy(busy), .done(done), .error(error)
  );

  // Game work RAM: one-cycle read latency.
  logic [7:0] ext_ram [1 << ADDR_W];
  always @(posedge clk_sys) if (ram_rd) ram_dout <= ext_ram[ram_addr];

  // Reference: what the HPS should see for each address.
  logic [7:0] model_buf [LEN];
  bit         model_valid;
  logic [7:0] last_exp;
  logic [7:0] exp_q [$];
  int         checks, errors;

  function automatic logic [7:0] exp_byte(input logic [24:0] a);
    if (!model_valid || a >= 25'(LEN)) return 8'hFF;
    return model_buf[int'(a)];
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Monitor: every completed read (ioctl_wait falling) is checked against the scoreboard.
  bit         prev_wait;
  int         wait_run, rd_seen;
  logic [7:0] mon_exp;
  always @(negedge clk_sys) begin
    if (ioctl_wait) wait_run++;
    if (prev_wait && !ioctl_wait) begin
      rd_seen++;
      checks++;
      if (wait_run != 1) begin
        errors++;
        $display("FAIL wait_len: got %0d cycles expected 1", wait_run);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL din_unexpected: got %02h expected no read", ioctl_din);
      end else begin
        mon_exp = exp_q.pop_front();
        if (ioctl_din !== mon_exp) begin
          errors++;
          $display("FAIL din: got %02h expected %02h", ioctl_din, mon_exp);
        end else begin
          $display("read %0d din=%02h", rd_seen, ioctl_din);
        end
      end
      wait_run = 0;
    end
    prev_wait = ioctl_wait;
  end

  task automatic hps_read(input logic [24:0] a);
    bit hold;
    hold = 1'($urandom_range(0, 1));
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    last_exp   = exp_byte(a);
    exp_q.push_back(last_exp);
    @(negedge clk_sys);
    if (!hold) ioctl_rd = 1'b0;   // holding rd into the wait cycle must be ignored
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk_sys);
  endtask

  task automatic foreign_read(input logic [24:0] a);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("foreign_wait", ioctl_wait, 1'b0);
    @(negedge clk_sys);
    check("foreign_wait2", ioctl_wait, 1'b0);
    check("foreign_din_held", ioctl_din, last_exp);
    check("foreign_no_ram_rd", ram_rd, 1'b0);
  endtask

  task automatic start_upload(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index  = idx;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_upload();
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("done_pulse", done, 1'b1);
    check("busy_after_done", busy, 1'b0);
    @(negedge clk_sys);
    check("done_single", done, 1'b0);
  endtask

  // Runs a save; abort_at >= 0 asserts reset when that RAM address is read.
  task automatic do_save(input int abort_at, output int elapsed);
    int n, idx, first_c, last_c, upl_cnt, req_c;
    bit prev_pause, aborted;
    @(negedge clk_sys);
    save_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!pause_req && n < 20);
    check("pause_req_rise", pause_req, 1'b1);
    check("error_cleared", error, 1'b0);
    repeat (10) @(negedge clk_sys);
    pause_ack = 1'b1;
    save_req  = 1'b0;
    idx = 0; first_c = -1; last_c = -1; upl_cnt = 0; req_c = -1;
    prev_pause = 1'b1; aborted = 1'b0;
    for (int c = 0; c < LEN + 6 && !aborted; c++) begin
      @(negedge clk_sys);
      if (ram_rd) begin
        check("ram_addr", 32'(ram_addr), 32'(idx));
        if (first_c < 0) first_c = c;
        last_c = c;
        idx++;
        if (idx - 1 == abort_at) begin
          reset     = 1'b1;
          pause_ack = 1'b0;
          @(negedge clk_sys);
          check("abort_pause_req", pause_req, 1'b0);
          check("abort_busy", busy, 1'b0);
          check("abort_wait", ioctl_wait, 1'b0);
          reset       = 1'b0;
          model_valid = 1'b0;
          aborted     = 1'b1;
        end
      end
      if (ioctl_upload_req) begin
        upl_cnt++;
        req_c = c;
        check("pause_drop_with_req", {prev_pause, pause_req}, 2'b10);
      end
      prev_pause = pause_req;
    end
    pause_ack = 1'b0;
    elapsed = 0;
    if (!aborted) begin
      check("ram_rd_count", idx, LEN);
      check("ram_rd_contiguous", last_c - first_c + 1, LEN);
      check("upload_req_count", upl_cnt, 1);
      check("busy_in_req", busy, 1'b1);
      for (int i = 0; i < LEN; i++) model_buf[i] = ext_ram[i];
      model_valid = 1'b1;
      elapsed = LEN + 5 - req_c;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int elapsed, n;
    int order [LEN];
    checks = 0; errors = 0; model_valid = 1'b0; last_exp = 8'h00;
    reset = 1'b1; save_req = 1'b0; pause_ack = 1'b0;
    ioctl_upload = 1'b0; ioctl_index = 8'h00; ioctl_rd = 1'b0; ioctl_addr = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) ext_ram[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(negedge clk_sys);
    check("reset_outputs", {pause_req, ram_rd, ram_addr, ioctl_din, ioctl_wait,
                            ioctl_upload_req, busy, done, error}, 0);
    reset = 1'b0;

    // HPS-initiated upload with nothing captured: all filler bytes.
    @(negedge clk_sys);
    check("busy_idle", busy, 1'b0);
    start_upload(IDX);
    check("busy_serve", busy, 1'b1);
    for (int i = 0; i < 6; i++) hps_read(25'($urandom_range(0, LEN - 1)));
    hps_read(25'(LEN));
    end_upload();

    // Snapshot RAM[i]=i^5A and read it back in random order plus out-of-range addresses.
    do_save(-1, elapsed);
    start_upload(IDX);
    for (int i = 0; i < LEN; i++) order[i] = i;
    for (int i = LEN - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < LEN; i++) hps_read(25'(order[i]));
    hps_read(25'(LEN));
    hps_read(25'h100000);
    hps_read(25'($urandom_range(LEN, (1 << 25) - 1)));
    end_upload();

    // No HPS response: error after TIMEOUT cycles in REQ.
    for (int i = 0; i < LEN; i++) ext_ram[i] = 8'($urandom);
    do_save(-1, elapsed);
    n = elapsed;
    while (!error && n < TIMEOUT + 50) begin
      @(negedge clk_sys);
      n++;
    end
    check("timeout_cycle", n, TIMEOUT);
    check("timeout_idle", busy, 1'b0);
    start_upload(IDX);
    for (int i = 0; i < 4; i++) hps_read(25'($urandom_range(0, LEN - 1)));
    end_upload();
    check("error_sticky", error, 1'b1);

    // New save clears error; save toggles and a foreign-index upload in REQ do nothing.
    for (int i = 0; i < LEN; i++) ext_ram[i] = 8'($urandom);
    do_save(-1, elapsed);
    for (int i = 0; i < LEN; i++) ext_ram[i] = ~ext_ram[i];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      save_req = 1'b1;
      @(negedge clk_sys);
      save_req = 1'b0;
      check("req_no_pause", pause_req, 1'b0);
      check("req_no_ram_rd", ram_rd, 1'b0);
    end
    start_upload(8'd3);
    for (int i = 0; i < 3; i++) foreign_read(25'($urandom_range(0, LEN - 1)));
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("foreign_no_done", done, 1'b0);
    check("foreign_still_req", busy, 1'b1);
    start_upload(IDX);
    for (int i = 0; i < 8; i++) hps_read(25'($urandom_range(0, LEN - 1)));
    end_upload();

    // Reset in the middle of COPY: the partial buffer must read as filler.
    do_save(30, elapsed);
    start_upload(IDX);
    for (int i = 0; i < 6; i++) hps_read(25'($urandom_range(0, LEN - 1)));
    end_upload();

    repeat (3) @(negedge clk_sys);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
